// File: rtl/core_pio_in_0_if.sv
// Avalon-MM slave bus of the parallel input port: word address, select, write strobe,
// write data and combinational read data.
interface core_pio_in_0_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/core_pio_in_0.sv
// Parallel input port: synchronizes WIDTH external inputs, optionally debounces them,
// captures edges into a RW1C register and raises a level interrupt on masked captures.
module core_pio_in_0 #(
    parameter int WIDTH           = 7,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    core_pio_in_0_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] s1_q, s2_q, prev_q, f, edges;
    logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d, clear_mask;
    logic             wr_en;
    logic             unused_wdata;

    // NOTE: clocked processes use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            s1_q      <= in_port;
            s2_q      <= s1_q;
            prev_q    <= f;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign f = s2_q;
        end else begin : g_debounce
            localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [WIDTH-1:0] f_q, f_d;
            logic [15:0]      cnt_q [WIDTH];
            logic [15:0]      cnt_d [WIDTH];

            // A bit's filtered value follows s2 only after it has differed for N straight cycles.
            always_comb begin
                f_d = f_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (s2_q[i] != f_q[i]) begin
                        if (cnt_q[i] == LAST) f_d[i] = s2_q[i];
                        else                  cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
            end

            // NOTE: the counter array is plain flop storage, so it is reset element by element like any register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    f_q <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    f_q <= f_d;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign f = f_q;
        end
    endgenerate

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
        edges      = '0;
        clear_mask = '0;
        irqmask_d  = irqmask_q;
        case (EDGE_TYPE)
            0:       edges = f & ~prev_q;
            1:       edges = ~f & prev_q;
            default: edges = f ^ prev_q;
        endcase
        if (wr_en && bus.address == 2'd3) clear_mask = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == 2'd2) irqmask_d  = bus.writedata[WIDTH-1:0];
        // A new edge on a bit being cleared in the same cycle keeps the bit set.
        edgecap_d = (edgecap_q & ~clear_mask) | edges;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = 32'(f);
            2'd2:    bus.readdata = 32'(irqmask_q);
            2'd3:    bus.readdata = 32'(edgecap_q);
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_core_pio_in_0.sv
// Bench for core_pio_in_0: three instances (no filter / 4-cycle filter / 8-cycle any-edge)
// driven in parallel and compared every cycle against a sample-history reference model.
module tb_core_pio_in_0;
    localparam int W  = 7;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs, wr_n;
    logic [31:0] wdata;
    logic [W-1:0] pin    [ND];
    logic [31:0]  rd     [ND];
    logic         irq_o  [ND];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_pio_in_0_if bus0 ();
    core_pio_in_0_if bus1 ();
    core_pio_in_0_if bus2 ();

    assign bus0.address = address; assign bus0.chipselect = cs;
    assign bus0.write_n = wr_n;    assign bus0.writedata  = wdata;
    assign bus1.address = address; assign bus1.chipselect = cs;
    assign bus1.write_n = wr_n;    assign bus1.writedata  = wdata;
    assign bus2.address = address; assign bus2.chipselect = cs;
    assign bus2.write_n = wr_n;    assign bus2.writedata  = wdata;
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign rd[2] = bus2.readdata;

    core_pio_in_0 #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(pin[0]), .irq(irq_o[0]));
    core_pio_in_0 #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(pin[1]), .irq(irq_o[1]));
    core_pio_in_0 #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(pin[2]), .irq(irq_o[2]));

    // Reference model: synchronizer stages, filtered value, last 8 s2 samples, registers.
    logic [W-1:0] m_s1 [ND], m_s2 [ND], m_f [ND], m_prev [ND], m_mask [ND], m_ec [ND];
    logic [W-1:0] m_hist [ND][8];

    function automatic int n_of(input int id);
        return (id == 0) ? 0 : (id == 1) ? 4 : 8;
    endfunction

    function automatic int et_of(input int id);
        return (id == 2) ? 2 : 0;
    endfunction

    function automatic logic [W-1:0] f_exp(input int id);
        return (n_of(id) == 0) ? m_s2[id] : m_f[id];
    endfunction

    function automatic logic [31:0] rd_exp(input int id, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(f_exp(id));
            2'd2:    return 32'(m_mask[id]);
            2'd3:    return 32'(m_ec[id]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < ND; id++) begin
            m_s1[id] = '0; m_s2[id] = '0; m_f[id] = '0;
            m_prev[id] = '0; m_mask[id] = '0; m_ec[id] = '0;
            for (int j = 0; j < 8; j++) m_hist[id][j] = '0;
        end
    endtask

    // One clock edge of the model, from the values present just before the edge.
    task automatic model_step(input int id, input logic [W-1:0] in_v, input logic wr,
                              input logic [1:0] a, input logic [31:0] wd);
        logic [W-1:0] fo, ed, clr;
        logic         all_diff;
        int           n;
        n  = n_of(id);
        fo = f_exp(id);
        if (et_of(id) == 0)      ed = fo & ~m_prev[id];
        else if (et_of(id) == 1) ed = ~fo & m_prev[id];
        else                     ed = fo ^ m_prev[id];
        clr = (wr && a == 2'd3) ? wd[W-1:0] : '0;
        m_ec[id] = (m_ec[id] & ~clr) | ed;
        if (wr && a == 2'd2) m_mask[id] = wd[W-1:0];
        m_prev[id] = fo;
        if (n > 0) begin
            for (int j = 7; j > 0; j--) m_hist[id][j] = m_hist[id][j-1];
            m_hist[id][0] = m_s2[id];
            // Flip a bit once its last n synchronized samples all disagree with it.
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < n; j++)
                    if (m_hist[id][j][b] == m_f[id][b]) all_diff = 1'b0;
                if (all_diff) m_f[id][b] = ~m_f[id][b];
            end
        end
        m_s2[id] = m_s1[id];
        m_s1[id] = in_v;
    endtask

    task automatic tick();
        logic [W-1:0] in_s [ND];
        logic         wr;
        logic [1:0]   a;
        logic [31:0]  wd;
        wr = cs && !wr_n;
        a  = address;
        wd = wdata;
        for (int id = 0; id < ND; id++) in_s[id] = pin[id];
        @(posedge clk);
        if (reset_n)
            for (int id = 0; id < ND; id++) model_step(id, in_s[id], wr, a, wd);
        #1;
    endtask

    task automatic check_all();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int id = 0; id < ND; id++)
                check($sformatf("model_d%0d_a%0d", id, a), rd[id], rd_exp(id, 2'(a)));
        end
        for (int id = 0; id < ND; id++)
            check($sformatf("model_d%0d_irq", id), 32'(irq_o[id]), 32'(|(m_ec[id] & m_mask[id])));
    endtask

    task automatic step();
        tick();
        cs   = 1'b0;
        wr_n = 1'b1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr_n = 1'b0; address = a; wdata = d;
        step();
    endtask

    task automatic rd_chk(input string tag, input int id, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, rd[id], exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int id = 0; id < ND; id++) begin
            rd_chk($sformatf("rst_d%0d_data", id), id, 2'd0, 32'd0);
            check($sformatf("rst_d%0d_irq", id), 32'(irq_o[id]), 32'd0);
        end
        tick();
        check_all();
        tick();
        reset_n = 1'b1;
        check_all();
    endtask

    task automatic run_random(input int cycles);
        int unsigned r;
        for (int c = 0; c < cycles; c++) begin
            r = $urandom_range(0, 99);
            if (r < 30) pin[0] = W'($urandom);
            for (int id = 1; id < ND; id++) begin
                r = $urandom_range(0, 99);
                if (r < 8) pin[id] = pin[id] ^ (W'(1) << $urandom_range(0, W - 1));
            end
            r = $urandom_range(0, 999);
            if (r < 3) do_reset();
            r = $urandom_range(0, 99);
            if (r < 10) bus_write(2'($urandom_range(0, 3)), $urandom);
            else        step();
        end
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; wr_n = 1'b1; address = 2'd0; wdata = '0;
        for (int id = 0; id < ND; id++) pin[id] = '0;
        model_reset();
        tick();
        for (int id = 0; id < ND; id++) begin
            rd_chk($sformatf("init_d%0d_data", id), id, 2'd0, 32'd0);
            check($sformatf("init_d%0d_irq", id), 32'(irq_o[id]), 32'd0);
        end
        tick();
        reset_n = 1'b1;
        steps(3);

        // Basic capture and interrupt on the unfiltered rising-edge instance.
        bus_write(2'd2, 32'h7F);
        rd_chk("mask_rd", 0, 2'd2, 32'h7F);
        pin[0] = 7'h05;
        step();
        rd_chk("lat_data_k", 0, 2'd0, 32'h00);
        step();
        rd_chk("lat_data_k1", 0, 2'd0, 32'h05);
        rd_chk("lat_ec_k1", 0, 2'd3, 32'h00);
        step();
        rd_chk("lat_ec_k2", 0, 2'd3, 32'h05);
        check("lat_irq_k2", 32'(irq_o[0]), 32'd1);

        // Write-one-to-clear.
        bus_write(2'd3, 32'h01);
        rd_chk("w1c_ec_01", 0, 2'd3, 32'h04);
        check("w1c_irq_01", 32'(irq_o[0]), 32'd1);
        bus_write(2'd3, 32'h04);
        rd_chk("w1c_ec_04", 0, 2'd3, 32'h00);
        check("w1c_irq_04", 32'(irq_o[0]), 32'd0);

        // Masking: captured bit 0 does not interrupt until its mask bit is set.
        bus_write(2'd2, 32'h02);
        pin[0] = 7'h04;
        steps(3);
        pin[0] = 7'h05;
        steps(3);
        rd_chk("mask_ec", 0, 2'd3, 32'h01);
        check("mask_irq_off", 32'(irq_o[0]), 32'd0);
        bus_write(2'd2, 32'h03);
        check("mask_irq_on", 32'(irq_o[0]), 32'd1);

        // Edge arriving in the same cycle as its clear wins.
        bus_write(2'd3, 32'h7F);
        pin[0] = 7'h07;
        steps(2);
        bus_write(2'd3, 32'h02);
        rd_chk("capture_wins", 0, 2'd3, 32'h02);

        // Debounce N=4: short glitch rejected, long level accepted.
        bus_write(2'd3, 32'h7F);
        pin[1] = 7'h04;
        steps(3);
        pin[1] = 7'h00;
        steps(8);
        rd_chk("glitch_data", 1, 2'd0, 32'h00);
        rd_chk("glitch_ec", 1, 2'd3, 32'h00);
        pin[1] = 7'h04;
        steps(5);
        rd_chk("deb_data_k4", 1, 2'd0, 32'h00);
        step();
        rd_chk("deb_data_k5", 1, 2'd0, 32'h04);
        rd_chk("deb_ec_k5", 1, 2'd3, 32'h00);
        step();
        rd_chk("deb_ec_k6", 1, 2'd3, 32'h04);

        // Any-edge instance with N=8: both directions captured; reset discards pending state.
        pin[2] = 7'h08;
        steps(12);
        rd_chk("any_rise_data", 2, 2'd0, 32'h08);
        rd_chk("any_rise_ec", 2, 2'd3, 32'h08);
        bus_write(2'd3, 32'h7F);
        pin[2] = 7'h00;
        steps(12);
        rd_chk("any_fall_ec", 2, 2'd3, 32'h08);
        bus_write(2'd3, 32'h7F);
        pin[2] = 7'h08;
        steps(4);
        pin[2] = 7'h00;
        do_reset();
        steps(20);
        rd_chk("rst_mid_data", 2, 2'd0, 32'h00);
        rd_chk("rst_mid_ec", 2, 2'd3, 32'h00);
        check("rst_mid_irq", 32'(irq_o[2]), 32'd0);

        run_random(1500);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
